// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: length-prefixed pt_mem -> ct_mem via external S RAM; en/rdy start handshake.
// Define ARC4_DROP_EN to discard the first 256 keystream bytes (RC4-drop[256]).
`timescale 1ns/1ps
module arc4_encrypt #(
   parameter int KEYLEN = 3
) (
   input  logic        CLOCK_50,
   input  logic        rst_n,
   input  logic        en,
   output logic        rdy,
   input  logic [23:0] key,
   output logic [7:0]  pt_addr,
   input  logic [7:0]  pt_rddata,
   output logic [7:0]  ct_addr,
   output logic [7:0]  ct_wrdata,
   output logic        ct_wren,
   output logic [7:0]  s_addr,
   input  logic [7:0]  s_rddata,
   output logic [7:0]  s_wrdata,
   output logic        s_wren
);

   typedef enum logic [4:0] {
      ST_IDLE, ST_INIT,
      ST_K0, ST_K1, ST_K2, ST_K3, ST_K4,
      ST_L0, ST_L1, ST_L2,
      ST_P0, ST_P1, ST_P2, ST_P3, ST_P4, ST_P5, ST_P6, ST_P7,
      ST_DONE
   } state_t;

   localparam logic [1:0] KIDX_LAST = 2'(KEYLEN - 1);

   state_t      state_q, state_d;
   logic [7:0]  i_q, i_d, j_q, j_d, k_q, k_d, len_q, len_d;
   logic [7:0]  si_q, si_d, sj_q, sj_d, pt_q, pt_d;
   logic [1:0]  kidx_q, kidx_d;
   logic [23:0] key_q, key_d;
   logic [7:0]  s_addr_q, s_addr_d, s_wrdata_q, s_wrdata_d;
   logic        s_wren_q, s_wren_d;
   logic [7:0]  pt_addr_q, pt_addr_d, ct_addr_q, ct_addr_d, ct_wrdata_q, ct_wrdata_d;
   logic        ct_wren_q, ct_wren_d;
   logic [7:0]  kbyte, j_ksa, j_prga;
`ifdef ARC4_DROP_EN
   logic        drop_q, drop_d;
   logic [7:0]  dcnt_q, dcnt_d;
`endif

   always_comb begin
      case (kidx_q)
         2'd0:    kbyte = key_q[23:16];
         2'd1:    kbyte = key_q[15:8];
         default: kbyte = key_q[7:0];
      endcase
   end

   assign j_ksa  = j_q + s_rddata + kbyte;
   assign j_prga = j_q + s_rddata;

   // Outputs are registered, so a read issued in state X returns data in state X+2.
   always_comb begin
      state_d     = state_q;
      i_d         = i_q;
      j_d         = j_q;
      k_d         = k_q;
      len_d       = len_q;
      si_d        = si_q;
      sj_d        = sj_q;
      pt_d        = pt_q;
      kidx_d      = kidx_q;
      key_d       = key_q;
      s_addr_d    = s_addr_q;
      s_wrdata_d  = s_wrdata_q;
      s_wren_d    = 1'b0;
      pt_addr_d   = pt_addr_q;
      ct_addr_d   = ct_addr_q;
      ct_wrdata_d = ct_wrdata_q;
      ct_wren_d   = 1'b0;
`ifdef ARC4_DROP_EN
      drop_d      = drop_q;
      dcnt_d      = dcnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (en) begin
               key_d   = key;
               i_d     = 8'd0;
               j_d     = 8'd0;
               k_d     = 8'd0;
               state_d = ST_INIT;
            end
         end
         ST_INIT: begin
            s_addr_d   = i_q;
            s_wrdata_d = i_q;
            s_wren_d   = 1'b1;
            i_d        = i_q + 8'd1;
            if (i_q == 8'hff) begin
               j_d     = 8'd0;
               kidx_d  = 2'd0;
               state_d = ST_K0;
            end
         end
         ST_K0: begin
            s_addr_d = i_q;
            state_d  = ST_K1;
         end
         ST_K1: state_d = ST_K2;
         ST_K2: begin
            si_d     = s_rddata;
            j_d      = j_ksa;
            s_addr_d = j_ksa;
            state_d  = ST_K3;
         end
         // S[j] is written before S[i]; the read of old S[j] lands in the RAM first.
         ST_K3: begin
            s_addr_d   = j_q;
            s_wrdata_d = si_q;
            s_wren_d   = 1'b1;
            state_d    = ST_K4;
         end
         ST_K4: begin
            s_addr_d   = i_q;
            s_wrdata_d = s_rddata;
            s_wren_d   = 1'b1;
            i_d        = i_q + 8'd1;
            kidx_d     = (kidx_q == KIDX_LAST) ? 2'd0 : kidx_q + 2'd1;
            state_d    = (i_q == 8'hff) ? ST_L0 : ST_K0;
         end
         ST_L0: begin
            pt_addr_d = 8'd0;
            state_d   = ST_L1;
         end
         ST_L1: state_d = ST_L2;
         ST_L2: begin
            len_d       = pt_rddata;
            ct_addr_d   = 8'd0;
            ct_wrdata_d = pt_rddata;
            ct_wren_d   = 1'b1;
            i_d         = 8'd0;
            j_d         = 8'd0;
            k_d         = 8'd1;
`ifdef ARC4_DROP_EN
            drop_d      = 1'b1;
            dcnt_d      = 8'd0;
`endif
            state_d     = (pt_rddata == 8'd0) ? ST_DONE : ST_P0;
         end
         ST_P0: begin
            i_d      = i_q + 8'd1;
            s_addr_d = i_q + 8'd1;
`ifdef ARC4_DROP_EN
            if (!drop_q) pt_addr_d = k_q;
`else
            pt_addr_d = k_q;
`endif
            state_d  = ST_P1;
         end
         ST_P1: state_d = ST_P2;
         ST_P2: begin
            si_d     = s_rddata;
            pt_d     = pt_rddata;
            j_d      = j_prga;
            s_addr_d = j_prga;
            state_d  = ST_P3;
         end
         ST_P3: begin
            s_addr_d   = j_q;
            s_wrdata_d = si_q;
            s_wren_d   = 1'b1;
            state_d    = ST_P4;
         end
         ST_P4: begin
            sj_d       = s_rddata;
            s_addr_d   = i_q;
            s_wrdata_d = s_rddata;
            s_wren_d   = 1'b1;
            state_d    = ST_P5;
         end
         ST_P5: begin
            s_addr_d = si_q + sj_q;
            state_d  = ST_P6;
         end
         ST_P6: state_d = ST_P7;
         ST_P7: begin
`ifdef ARC4_DROP_EN
            if (drop_q) begin
               if (dcnt_q == 8'hff) drop_d = 1'b0;
               dcnt_d  = dcnt_q + 8'd1;
               state_d = ST_P0;
            end else begin
`else
            begin
`endif
               ct_addr_d   = k_q;
               ct_wrdata_d = pt_q ^ s_rddata;
               ct_wren_d   = 1'b1;
               if (k_q == len_q) begin
                  state_d = ST_DONE;
               end else begin
                  k_d     = k_q + 8'd1;
                  state_d = ST_P0;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         i_q         <= 8'd0;
         j_q         <= 8'd0;
         k_q         <= 8'd0;
         len_q       <= 8'd0;
         si_q        <= 8'd0;
         sj_q        <= 8'd0;
         pt_q        <= 8'd0;
         kidx_q      <= 2'd0;
         key_q       <= 24'd0;
         s_addr_q    <= 8'd0;
         s_wrdata_q  <= 8'd0;
         s_wren_q    <= 1'b0;
         pt_addr_q   <= 8'd0;
         ct_addr_q   <= 8'd0;
         ct_wrdata_q <= 8'd0;
         ct_wren_q   <= 1'b0;
`ifdef ARC4_DROP_EN
         drop_q      <= 1'b0;
         dcnt_q      <= 8'd0;
`endif
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         j_q         <= j_d;
         k_q         <= k_d;
         len_q       <= len_d;
         si_q        <= si_d;
         sj_q        <= sj_d;
         pt_q        <= pt_d;
         kidx_q      <= kidx_d;
         key_q       <= key_d;
         s_addr_q    <= s_addr_d;
         s_wrdata_q  <= s_wrdata_d;
         s_wren_q    <= s_wren_d;
         pt_addr_q   <= pt_addr_d;
         ct_addr_q   <= ct_addr_d;
         ct_wrdata_q <= ct_wrdata_d;
         ct_wren_q   <= ct_wren_d;
`ifdef ARC4_DROP_EN
         drop_q      <= drop_d;
         dcnt_q      <= dcnt_d;
`endif
      end
   end

   assign rdy       = (state_q == ST_IDLE);
   assign s_addr    = s_addr_q;
   assign s_wrdata  = s_wrdata_q;
   assign s_wren    = s_wren_q;
   assign pt_addr   = pt_addr_q;
   assign ct_addr   = ct_addr_q;
   assign ct_wrdata = ct_wrdata_q;
   assign ct_wren   = ct_wren_q;

endmodule

// File: tb/tb_arc4_encrypt.sv
// Bench for arc4_encrypt: synchronous RAM models, software RC4 reference, ct write scoreboard.
`timescale 1ns/1ps
module tb_arc4_encrypt;

`ifdef ARC4_DROP_EN
   localparam int DROP = 256;
`else
   localparam int DROP = 0;
`endif

   logic        CLOCK_50 = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [23:0] key = 24'd0;
   logic        rdy;
   logic [7:0]  pt_addr, pt_rddata, ct_addr, ct_wrdata, s_addr, s_rddata, s_wrdata;
   logic        ct_wren, s_wren;

   arc4_encrypt dut (
      .CLOCK_50  (CLOCK_50),
      .rst_n     (rst_n),
      .en        (en),
      .rdy       (rdy),
      .key       (key),
      .pt_addr   (pt_addr),
      .pt_rddata (pt_rddata),
      .ct_addr   (ct_addr),
      .ct_wrdata (ct_wrdata),
      .ct_wren   (ct_wren),
      .s_addr    (s_addr),
      .s_rddata  (s_rddata),
      .s_wrdata  (s_wrdata),
      .s_wren    (s_wren)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   logic [7:0] pt_mem [256];
   logic [7:0] ct_mem [256];
   logic [7:0] s_mem  [256];

   always @(posedge CLOCK_50) begin
      if (s_wren) s_mem[s_addr] <= s_wrdata;
      s_rddata  <= s_mem[s_addr];
      pt_rddata <= pt_mem[pt_addr];
      if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] d;
   } ct_exp_t;

   ct_exp_t    sb [$];
   int         n_ct_wr = 0;
   int         idle_viol = 0;
   logic [7:0] last_ct_addr = 8'd0;
   logic [7:0] msg [256];
   logic [7:0] ks  [256];
   logic [7:0] kv  [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

   always @(negedge CLOCK_50) begin
      if (rst_n) begin
         if (rdy && (s_wren || ct_wren)) idle_viol++;
         if (ct_wren) begin
            n_ct_wr++;
            last_ct_addr = ct_addr;
            if (sb.size() == 0) begin
               check("ct_unexpected", 32'(sb.size()), 32'd1);
            end else begin
               ct_exp_t e;
               e = sb.pop_front();
               check("ct_addr", 32'(ct_addr), 32'(e.a));
               check("ct_data", 32'(ct_wrdata), 32'(e.d));
            end
         end
      end
   end

   task automatic gen_ks(input logic [23:0] k, input int n);
      logic [7:0] s [256];
      logic [7:0] i, j, t, kb, idx;
      for (int x = 0; x < 256; x++) s[x] = 8'(x);
      j = 8'd0;
      for (int x = 0; x < 256; x++) begin
         kb   = k[23 - 8*(x % 3) -: 8];
         j    = j + s[x] + kb;
         t    = s[x];
         s[x] = s[j];
         s[j] = t;
      end
      i = 8'd0;
      j = 8'd0;
      for (int x = 0; x < DROP + n; x++) begin
         i    = i + 8'd1;
         j    = j + s[i];
         t    = s[i];
         s[i] = s[j];
         s[j] = t;
         idx  = s[i] + s[j];
         if (x >= DROP) ks[x - DROP] = s[idx];
      end
   endtask

   task automatic load_and_expect(input logic [23:0] k, input int len);
      pt_mem[0] = 8'(len);
      for (int n = 1; n <= len; n++) pt_mem[n] = msg[n];
      gen_ks(k, len);
      sb.push_back('{a: 8'd0, d: 8'(len)});
      for (int n = 1; n <= len; n++) sb.push_back('{a: 8'(n), d: msg[n] ^ ks[n-1]});
   endtask

   task automatic start_run(input logic [23:0] k);
      @(negedge CLOCK_50);
      key = k;
      en  = 1'b1;
      @(negedge CLOCK_50);
      en  = 1'b0;
      check("rdy_busy", 32'(rdy), 32'd0);
   endtask

   task automatic wait_rdy(output int cyc);
      cyc = 0;
      while (!rdy && cyc < 10000) begin
         @(negedge CLOCK_50);
         cyc++;
      end
      check("rdy_done", 32'(rdy), 32'd1);
   endtask

   task automatic wait_done(input int len);
      int cyc;
      wait_rdy(cyc);
      check("run_len_bound", 32'(cyc < 1548 + 9*len + 9*DROP), 32'd1);
      check("ct_wr_count", 32'(n_ct_wr), 32'(len + 1));
      check("sb_empty", 32'(sb.size()), 32'd0);
   endtask

   task automatic load_key_msg();
      string p;
      p = "Plaintext";
      for (int n = 0; n < 9; n++) msg[n+1] = p[n];
   endtask

   initial begin
      int cyc;
      int mism;
      logic [23:0] kk;

      repeat (3) @(negedge CLOCK_50);
      check("rst_rdy", 32'(rdy), 32'd1);
      check("rst_addr", 32'({s_addr, pt_addr, ct_addr}), 32'd0);
      check("rst_wr", 32'({s_wrdata, ct_wrdata, s_wren, ct_wren}), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge CLOCK_50);

      // Known-answer vector
      load_key_msg();
      n_ct_wr = 0;
      load_and_expect(24'h4B6579, 9);
      start_run(24'h4B6579);
      wait_done(9);
      if (DROP == 0) begin
         for (int n = 0; n < 10; n++) check("kv_ct", 32'(ct_mem[n]), 32'(kv[n]));
      end else begin
         check("kv_ct0", 32'(ct_mem[0]), 32'h09);
      end

      // Empty message
      n_ct_wr = 0;
      load_and_expect(24'($urandom), 0);
      start_run(24'h123456);
      wait_done(0);
      check("l0_last_addr", 32'(last_ct_addr), 32'd0);

      // Full-length message and round trip
      for (int n = 1; n < 256; n++) msg[n] = 8'($urandom);
      n_ct_wr = 0;
      load_and_expect(24'h1E4600, 255);
      start_run(24'h1E4600);
      wait_done(255);
      check("l255_len", 32'(ct_mem[0]), 32'd255);
      check("l255_last_addr", 32'(last_ct_addr), 32'd255);
      gen_ks(24'h1E4600, 255);
      mism = 0;
      for (int n = 1; n < 256; n++) if ((ct_mem[n] ^ ks[n-1]) !== msg[n]) mism++;
      check("roundtrip", 32'(mism), 32'd0);

      // Back-to-back runs with en held, key disturbed mid-run
      kk = 24'hA5C311;
      for (int n = 1; n <= 20; n++) msg[n] = 8'($urandom);
      n_ct_wr = 0;
      load_and_expect(kk, 20);
      load_and_expect(kk, 20);
      @(negedge CLOCK_50);
      key = kk;
      en  = 1'b1;
      @(negedge CLOCK_50);
      check("b2b_busy", 32'(rdy), 32'd0);
      repeat (300) @(negedge CLOCK_50);
      key = ~kk;
      repeat (900) @(negedge CLOCK_50);
      key = kk;
      wait_rdy(cyc);
      @(negedge CLOCK_50);
      check("b2b_restart", 32'(rdy), 32'd0);
      en = 1'b0;
      wait_rdy(cyc);
      check("b2b_ct_count", 32'(n_ct_wr), 32'd42);
      check("b2b_sb_empty", 32'(sb.size()), 32'd0);

      // Reset during KSA, then rerun
      load_key_msg();
      pt_mem[0] = 8'd9;
      for (int n = 1; n <= 9; n++) pt_mem[n] = msg[n];
      start_run(24'h4B6579);
      repeat (400) @(negedge CLOCK_50);
      #3 rst_n = 1'b0;
      @(negedge CLOCK_50);
      check("abort_rdy", 32'(rdy), 32'd1);
      check("abort_wren", 32'({s_wren, ct_wren}), 32'd0);
      check("abort_saddr", 32'(s_addr), 32'd0);
      sb.delete();
      rst_n = 1'b1;
      @(negedge CLOCK_50);
      n_ct_wr = 0;
      load_and_expect(24'h4B6579, 9);
      start_run(24'h4B6579);
      wait_done(9);
      check("rerun_ct0", 32'(ct_mem[0]), 32'h09);

      check("idle_wren", 32'(idle_viol), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
